// File: rtl/mem_access_ctrl.sv
// Load/store access controller: core request -> fixed-latency RAM cycles, with sub-word RMW
// and load lane formatting. Define MEMCTL_UNALIGNED_ROTATE_EN for ARMv4 rotated unaligned LDR.
module mem_access_ctrl #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  fault,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  mem_cs,
  output logic                  mem_we,
  output logic                  mem_oe
);

  localparam int NUM_LANES = DATA_WIDTH / 8;

  typedef enum logic [2:0] {IDLE, RD, CAP, WR, DONE} state_t;

  state_t                state, state_nx;
  logic [ADDR_WIDTH-1:0] a_addr;
  logic [1:0]            a_size;
  logic                  a_signed, a_we, a_fault;
  logic [DATA_WIDTH-1:0] a_wdata;
  logic                  misalign;

  always_comb begin
    misalign = (req_size == 2'b01) && req_addr[0];
`ifndef MEMCTL_UNALIGNED_ROTATE_EN
    if (req_size[1] && (req_addr[1:0] != 2'b00)) misalign = 1'b1;
`endif
  end

  // Controls decode straight from state so an async reset drops them at once.
  always_comb begin
    state_nx = state;
    busy     = (state != IDLE);
    done     = (state == DONE);
    fault    = (state == DONE) && a_fault;
    mem_cs   = 1'b0;
    mem_oe   = 1'b0;
    mem_we   = 1'b0;
    case (state)
      IDLE: if (req) begin
        if (misalign)                 state_nx = DONE;
        else if (req_we && req_size[1]) state_nx = WR;
        else                          state_nx = RD;
      end
      RD: begin
        mem_cs = 1'b1; mem_oe = 1'b1;
        state_nx = CAP;
      end
      CAP: begin
        mem_cs = 1'b1; mem_oe = 1'b1;
        state_nx = a_we ? WR : DONE;
      end
      WR: begin
        mem_cs = 1'b1; mem_we = 1'b1;
        state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Load formatting, little-endian lanes.
  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;
  logic [DATA_WIDTH-1:0] ld_word, ld_val;

  always_comb begin
    ld_byte = mem_rdata[{a_addr[1:0], 3'b000} +: 8];
    ld_half = a_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    ld_word = mem_rdata;
`ifdef MEMCTL_UNALIGNED_ROTATE_EN
    case (a_addr[1:0])
      2'd1:    ld_word = {mem_rdata[7:0],  mem_rdata[31:8]};
      2'd2:    ld_word = {mem_rdata[15:0], mem_rdata[31:16]};
      2'd3:    ld_word = {mem_rdata[23:0], mem_rdata[31:24]};
      default: ld_word = mem_rdata;
    endcase
`endif
    case (a_size)
      2'b00:   ld_val = {{24{a_signed & ld_byte[7]}}, ld_byte};
      2'b01:   ld_val = {{16{a_signed & ld_half[15]}}, ld_half};
      default: ld_val = ld_word;
    endcase
  end

  // Store merge: each lane either takes new data or keeps the captured RAM byte.
  logic [NUM_LANES-1:0][7:0] merged;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    localparam logic [1:0] LANE = 2'(i);
    logic       hit;
    logic [7:0] src;
    assign hit = (a_size == 2'b00) ? (a_addr[1:0] == LANE) : (a_addr[1] == LANE[1]);
    assign src = (a_size == 2'b00) ? a_wdata[7:0] : a_wdata[8*(i%2) +: 8];
    assign merged[i] = hit ? src : mem_rdata[8*i +: 8];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      a_addr   <= '0;
      a_size   <= '0;
      a_signed <= 1'b0;
      a_we     <= 1'b0;
      a_fault  <= 1'b0;
      a_wdata  <= '0;
      rdata    <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && req) begin
        a_addr   <= req_addr;
        a_size   <= req_size;
        a_signed <= req_signed;
        a_we     <= req_we;
        a_fault  <= misalign;
        a_wdata  <= req_wdata;
      end
      // RAM data is only valid while enables are up, so take it at the end of CAP.
      if (state == CAP) begin
        if (a_we) a_wdata <= merged;
        else      rdata   <= ld_val;
      end
    end
  end

  assign mem_addr  = {a_addr[ADDR_WIDTH-1:2], 2'b00};
  assign mem_wdata = a_wdata;

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

- Load/store access controller between the ARMv4 core's memory stage and the byte-addressed, 32-bit-port synchronous RAM.
- Converts one core request (LDR/STR/LDRB/STRB/LDRH/STRH/LDRSB/LDRSH) into RAM chip-select, read and write cycles.
- Sub-word stores are done as read-modify-write. Load data is lane-selected, extended and, where applicable, rotated.
- Fixed-latency FSM with a req/done handshake back to the core.

## Interface
- ADDR_WIDTH, 14, byte address width, shared with the RAM.
- DATA_WIDTH, 32, core and RAM word width; fixed at 32.
- clk  input  1  single clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- req  input  1  request strobe; sampled only in IDLE.
- req_we  input  1  1 = store, 0 = load.
- req_size  input  2  00 byte, 01 halfword, 10 word; 11 is treated as word.
- req_signed  input  1  sign-extend sub-word loads.
- req_addr  input  ADDR_WIDTH  byte address.
- req_wdata  input  32  store data; the sub-word value sits in the low bits.
- busy  output  1  high while state ≠ IDLE.
- done  output  1  one-cycle completion pulse.
- fault  output  1  valid with done; misaligned access, no memory cycle performed.
- rdata  output  32  load result; holds until the next load completes.
- mem_addr  output  ADDR_WIDTH  RAM address, always word-aligned ({addr[AW-1:2],2'b00}).
- mem_wdata  output  32  RAM write data.
- mem_rdata  input  32  RAM read data; only valid while mem_cs & mem_oe & !mem_we.
- mem_cs, mem_we, mem_oe  output  1 each  RAM controls.

## Operation
- States: IDLE, RD, CAP, WR, DONE.
- **Request capture:** in IDLE with req=1, latch addr/size/signed/we/wdata and check alignment.
  - Halfword with addr[0]=1 → DONE with fault=1.
  - Word with addr[1:0]≠0: see Configuration.
- **Transitions:**
  - Load: IDLE→RD→CAP→DONE.
  - Word store: IDLE→WR→DONE.
  - Byte/halfword store: IDLE→RD→CAP→WR→DONE.
  - Fault: IDLE→DONE.
  - DONE→IDLE always.
- **RAM controls per state:**
  - RD and CAP drive cs=1, oe=1, we=0.
  - WR drives cs=1, we=1, oe=0.
  - IDLE and DONE drive all three at 0.
- **Read capture:** CAP registers mem_rdata, because RAM output is valid only while enables stay asserted.
- **Load formatting, little-endian:**
  - Byte: lane = addr[1:0].
  - Halfword: lane = addr[1].
  - Result is zero- or sign-extended per req_signed; req_signed is ignored for word loads.
- **Store merge:** replace the addressed byte or halfword lane of the captured word with req_wdata[7:0] or [15:0]. Other lanes are unchanged.
- **Flow control:**
  - req while busy is ignored; there is no queueing.
  - The RAM's completion flag is not consumed; timing is fixed.
- **Reset values:** all outputs 0 (rdata=0, done=0, fault=0, busy=0, mem_* = 0); state IDLE.
- **Reset mid-operation:** controls drop immediately and asynchronously. A store in WR is not performed unless its write edge has already occurred. No done is issued for the aborted request.

## Timing
- E0 is the rising edge sampling req=1 in IDLE; busy=1 from the cycle after E0 through the DONE cycle.
- Load: RD after E0, CAP after E1, rdata updated at E2, done=1 in the cycle after E2.
- Word store: WR after E0, RAM writes at E1, done=1 in the cycle after E1.
- Sub-word store: RD, CAP, WR, RAM writes at E3, done=1 in the cycle after E3.
- Fault: done=1 and fault=1 in the cycle after E0; fault is 0 whenever done is 0.
- Earliest next accept: the edge ending the DONE cycle plus one, i.e. IDLE must be entered first.

## Configuration
- MEMCTL_UNALIGNED_ROTATE_EN.
- **Defined:** a word load with addr[1:0]≠0 reads the aligned word and rotates it right by 8×addr[1:0] (ARMv4 LDR semantics). An unaligned word store writes the aligned word with the address low bits ignored; fault stays 0.
- **Undefined:** any word access with addr[1:0]≠0 takes the fault path with no RAM cycle.

## Test plan
- STR 0xDEADBEEF @0x010, then LDR @0x010 → rdata 0xDEADBEEF; done in the cycle after E2 for the load and after E1 for the store; mem_addr=0x010.
- STRB 0x5A @0x012 → RD, CAP, WR sequence observed; then LDR @0x010 → 0xDE5ABEEF.
- With memory 0xDE5ABEEF @0x010:
  - LDRSH @0x012 → 0xFFFFDE5A.
  - LDRH @0x012 → 0x0000DE5A.
  - LDRSB @0x013 → 0xFFFFFFDE.
  - LDRB @0x010 → 0x000000EF.
- LDR @0x011:
  - With macro → rdata 0xEFDE5ABE, fault=0.
  - Without macro → done=fault=1 in the cycle after E0, mem_cs never asserted, rdata unchanged.
- LDRH @0x011 → fault=1, no RAM cycle. req pulsed during busy → ignored, exactly one done.
- rst asserted during the WR cycle of STRB 0x77 @0x010 → mem_we and busy drop immediately, no done, memory still 0xDE5ABEEF.
